// File: rtl/matmul_sequencer_if.sv
// Handshake, MAC strobe and ROM/RAM address bundle between the matmul sequencer
// (master) and the engine datapath / host (slave).
interface matmul_sequencer_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int CNT_WIDTH  = 24
);
  logic                  start;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic                  clear;
  logic                  mult;
  logic                  sum;
  logic                  write;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [CNT_WIDTH-1:0]  cycle_count;

  modport master (
    input  start, stall,
    output busy, done, clear, mult, sum, write,
    output a_addr, b_addr, c_addr, d_addr, cycle_count
  );

  modport slave (
    output start, stall,
    input  busy, done, clear, mult, sum, write,
    input  a_addr, b_addr, c_addr, d_addr, cycle_count
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequencer for D = A*B + C: walks (row, col, chunk) in row-major order, driving the
// MAC strobes and ROM/RAM word addresses behind a start/busy/done handshake.
module matmul_sequencer #(
  parameter int ADDR_WIDTH = 7,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int INNER      = 128,
  parameter int LANES      = 4,
  parameter int A_BASE     = 0,
  parameter int B_BASE     = 0,
  parameter int C_BASE     = 64,
  parameter int D_BASE     = 64,
  parameter int CNT_WIDTH  = 24
) (
  input  logic               clock,
  input  logic               reset,
  matmul_sequencer_if.master bus
);

  localparam int KW  = INNER / LANES;
  localparam int R_W = $clog2(ROWS + 1);
  localparam int C_W = $clog2(COLS + 1);
  localparam int K_W = $clog2(KW + 1);

  localparam logic [R_W-1:0]       ROW_LAST = R_W'(ROWS - 1);
  localparam logic [C_W-1:0]       COL_LAST = C_W'(COLS - 1);
  localparam logic [K_W-1:0]       K_LAST   = K_W'(KW - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MULT  = 3'd2,
    ST_ADD   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [R_W-1:0]        row_r, row_s;
  logic [C_W-1:0]        col_r, col_s;
  logic [K_W-1:0]        k_r, k_s;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0] a_addr_r, a_addr_s;
  logic [ADDR_WIDTH-1:0] b_addr_r, b_addr_s;
  logic [ADDR_WIDTH-1:0] c_addr_r, c_addr_s;
  logic [ADDR_WIDTH-1:0] d_addr_r, d_addr_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  in_busy_s;
  logic                  clear_s, mult_s, sum_s, write_s;

  // Word address of element (major, minor) in a matrix laid out with the given stride.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input int base, input int major,
                                                    input int stride, input int minor);
    addr_of = ADDR_WIDTH'(base + major * stride + minor);
  endfunction

  // Busy-state decode of the registered state, used by the cycle counter.
  always_comb begin
    in_busy_s = 1'b0;
    case (state_r)
      ST_CLEAR, ST_MULT, ST_ADD, ST_WRITE: in_busy_s = 1'b1;
      default:                             in_busy_s = 1'b0;
    endcase
  end

  // Next state, loop indices and saturating cycle counter; stall freezes the busy states.
  always_comb begin
    state_s = state_r;
    row_s   = row_r;
    col_s   = col_r;
    k_s     = k_r;
    cnt_s   = cnt_r;
    if (in_busy_s && !bus.stall && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_WIDTH'(1);
    end else begin
      cnt_s = cnt_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_CLEAR;
          row_s   = '0;
          col_s   = '0;
          k_s     = '0;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (bus.stall) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_MULT;
        end
      end
      ST_MULT: begin
        if (bus.stall) begin
          state_s = ST_MULT;
        end else if (k_r == K_LAST) begin
          state_s = ST_ADD;
          k_s     = '0;
        end else begin
          k_s = k_r + K_W'(1);
        end
      end
      ST_ADD: begin
        if (bus.stall) begin
          state_s = ST_ADD;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.stall) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ((row_r == ROW_LAST) && (col_r == COL_LAST)) ? ST_DONE : ST_CLEAR;
          if (col_r == COL_LAST) begin
            col_s = '0;
            row_s = row_r + R_W'(1);
          end else begin
            col_s = col_r + C_W'(1);
          end
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Addresses and status for the state being entered, so they line up with its strobe.
  always_comb begin
    a_addr_s = addr_of(A_BASE, int'(row_s), KW, int'(k_s));
    b_addr_s = addr_of(B_BASE, int'(col_s), KW, int'(k_s));
    c_addr_s = addr_of(C_BASE, int'(row_s), COLS, int'(col_s));
    d_addr_s = addr_of(D_BASE, int'(row_s), COLS, int'(col_s));
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_s)
      ST_CLEAR, ST_MULT, ST_ADD, ST_WRITE: busy_s = 1'b1;
      ST_DONE:                             done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // MAC/RAM strobes: one per busy state, all suppressed while stalled.
  always_comb begin
    clear_s = 1'b0;
    mult_s  = 1'b0;
    sum_s   = 1'b0;
    write_s = 1'b0;
    if (!bus.stall) begin
      case (state_r)
        ST_CLEAR: clear_s = 1'b1;
        ST_MULT:  mult_s  = 1'b1;
        ST_ADD:   sum_s   = 1'b1;
        ST_WRITE: write_s = 1'b1;
        default:  clear_s = 1'b0;
      endcase
    end else begin
      clear_s = 1'b0;
    end
  end

  // State, index, counter and registered-output update with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      row_r    <= '0;
      col_r    <= '0;
      k_r      <= '0;
      cnt_r    <= '0;
      a_addr_r <= addr_of(A_BASE, 0, 0, 0);
      b_addr_r <= addr_of(B_BASE, 0, 0, 0);
      c_addr_r <= addr_of(C_BASE, 0, 0, 0);
      d_addr_r <= addr_of(D_BASE, 0, 0, 0);
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      row_r    <= row_s;
      col_r    <= col_s;
      k_r      <= k_s;
      cnt_r    <= cnt_s;
      a_addr_r <= a_addr_s;
      b_addr_r <= b_addr_s;
      c_addr_r <= c_addr_s;
      d_addr_r <= d_addr_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.clear       = clear_s;
  assign bus.mult        = mult_s;
  assign bus.sum         = sum_s;
  assign bus.write       = write_s;
  assign bus.a_addr      = a_addr_r;
  assign bus.b_addr      = b_addr_r;
  assign bus.c_addr      = c_addr_r;
  assign bus.d_addr      = d_addr_r;
  assign bus.cycle_count = cnt_r;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized bench for matmul_sequencer: main 2x2 config against a step-list model,
// plus a 4-bit-address wrap instance and a 4-bit-counter saturation instance.
module tb_matmul_sequencer;
  localparam int M_ROWS  = 2;
  localparam int M_COLS  = 2;
  localparam int M_KW    = 2;
  localparam int M_A     = 0;
  localparam int M_B     = 32;
  localparam int M_C     = 64;
  localparam int M_D     = 64;
  localparam int SAT_MAX = 15;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    int d;
  } step_t;

  logic  clock = 1'b0;
  logic  reset;
  logic  start;
  logic  stall;
  int    n_cmp = 0;
  int    n_err = 0;
  step_t exp_q[$];

  always #5 clock = ~clock;

  matmul_sequencer_if #(.ADDR_WIDTH(7), .CNT_WIDTH(24)) mif ();
  matmul_sequencer_if #(.ADDR_WIDTH(7), .CNT_WIDTH(4))  sif ();
  matmul_sequencer_if #(.ADDR_WIDTH(4), .CNT_WIDTH(24)) wif ();

  assign mif.start = start;
  assign mif.stall = stall;
  assign sif.start = start;
  assign sif.stall = stall;
  assign wif.start = start;
  assign wif.stall = stall;

  matmul_sequencer #(.ADDR_WIDTH(7), .ROWS(2), .COLS(2), .INNER(8), .LANES(4), .A_BASE(0),
    .B_BASE(32), .C_BASE(64), .D_BASE(64), .CNT_WIDTH(24)) dut (.clock(clock), .reset(reset), .bus(mif));
  matmul_sequencer #(.ADDR_WIDTH(7), .ROWS(2), .COLS(2), .INNER(8), .LANES(4), .A_BASE(0),
    .B_BASE(32), .C_BASE(64), .D_BASE(64), .CNT_WIDTH(4)) dut_sat (.clock(clock), .reset(reset), .bus(sif));
  matmul_sequencer #(.ADDR_WIDTH(4), .ROWS(1), .COLS(4), .INNER(8), .LANES(4), .A_BASE(0),
    .B_BASE(0), .C_BASE(64), .D_BASE(14), .CNT_WIDTH(24)) dut_wrap (.clock(clock), .reset(reset), .bus(wif));

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [63:0] exp_full(input logic [3:0] strb, input logic b, input logic d,
                                           input int cnt, input int aa, input int ba,
                                           input int ca, input int da);
    return {6'd0, strb, b, d, 24'(cnt), 7'(aa), 7'(ba), 7'(ca), 7'(da)};
  endfunction

  function automatic logic [63:0] obs_full();
    return {6'd0, mif.clear, mif.mult, mif.sum, mif.write, mif.busy, mif.done, mif.cycle_count,
            mif.a_addr, mif.b_addr, mif.c_addr, mif.d_addr};
  endfunction

  function automatic logic [63:0] ctl_word(input logic [3:0] strb, input logic b, input logic d,
                                           input int cnt);
    return {34'd0, strb, b, d, 24'(cnt)};
  endfunction

  function automatic logic [63:0] obs_ctl();
    return {34'd0, mif.clear, mif.mult, mif.sum, mif.write, mif.busy, mif.done, mif.cycle_count};
  endfunction

  function automatic int sat(input int v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  // Reference: every unstalled busy cycle of one operation, in order (kind 0..3 = clear..write).
  function automatic void build_model();
    step_t s;
    exp_q.delete();
    for (int r = 0; r < M_ROWS; r++) begin
      for (int c = 0; c < M_COLS; c++) begin
        s = '{kind: 0, a: M_A + r * M_KW, b: M_B + c * M_KW,
              c: (M_C + r * M_COLS + c) % 128, d: (M_D + r * M_COLS + c) % 128};
        exp_q.push_back(s);
        for (int k = 0; k < M_KW; k++) begin
          exp_q.push_back('{kind: 1, a: s.a + k, b: s.b + k, c: s.c, d: s.d});
        end
        exp_q.push_back('{kind: 2, a: s.a, b: s.b, c: s.c, d: s.d});
        exp_q.push_back('{kind: 3, a: s.a, b: s.b, c: s.c, d: s.d});
      end
    end
  endfunction

  // Called #1 after a negedge while the sequencer sits in an active ADD cycle.
  task automatic do_abort();
    #1 reset = 1'b1;
    #1;
    check_val("rst_async", obs_full(), exp_full(4'b0000, 1'b0, 1'b0, 0, M_A, M_B, M_C, M_D));
    #1;
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      check_val("rst_idle", obs_ctl(), ctl_word(4'b0000, 1'b0, 1'b0, 0));
    end
  endtask

  task automatic run_op(input int stall_pct, input bit poke, input int stall_at, input int abort_at);
    int          pos = 0;
    int          ucnt = 0;
    int          guard = 0;
    int          held = 0;
    int          m_writes = 0;
    int          w_q[$];
    logic [3:0]  strb;
    @(negedge clock);
    start = 1'b1;
    stall = 1'($urandom_range(1));
    @(negedge clock);
    start = 1'b0;
    while (pos < exp_q.size() && guard < 500) begin
      stall = ((pos == stall_at) && (held < 3)) || (int'($urandom_range(99)) < stall_pct);
      if (stall && (pos == stall_at)) held++;
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      #1;
      strb = stall ? 4'b0000 : (4'b1000 >> exp_q[pos].kind);
      check_val("busy", obs_full(), exp_full(strb, 1'b1, 1'b0, ucnt, exp_q[pos].a,
                exp_q[pos].b, exp_q[pos].c, exp_q[pos].d));
      check_val("sat_cnt", 64'(sif.cycle_count), 64'(sat(ucnt)));
      if (wif.write) w_q.push_back(int'(wif.d_addr));
      if (mif.write) m_writes++;
      if ((pos == abort_at) && !stall) begin
        do_abort();
        return;
      end
      if (!stall) begin
        pos++;
        ucnt++;
      end
      guard++;
      @(negedge clock);
    end
    check_val("guard", 64'(pos), 64'(exp_q.size()));
    stall = 1'($urandom_range(1));
    start = poke;
    #1;
    check_val("done", obs_ctl(), ctl_word(4'b0000, 1'b0, 1'b1, ucnt));
    check_val("sat_done", 64'(sif.cycle_count), 64'(sat(ucnt)));
    @(negedge clock);
    start = 1'b0;
    stall = 1'($urandom_range(1));
    #1;
    check_val("idle", obs_ctl(), ctl_word(4'b0000, 1'b0, 1'b0, ucnt));
    check_val("sat_idle", 64'(sif.cycle_count), 64'(sat(ucnt)));
    check_val("writes", 64'(m_writes), 64'(M_ROWS * M_COLS));
    check_val("wrap_n", 64'(w_q.size()), 64'd4);
    for (int i = 0; i < w_q.size() && i < 4; i++) begin
      check_val("wrap_addr", 64'(w_q[i]), 64'((14 + i) % 16));
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    build_model();
    #2 reset = 1'b1;
    #1;
    check_val("rst_init", obs_full(), exp_full(4'b0000, 1'b0, 1'b0, 0, M_A, M_B, M_C, M_D));
    check_val("rst_wrap", 64'(wif.d_addr), 64'd14);
    check_val("rst_sat", 64'(sif.cycle_count), 64'd0);
    #9 reset = 1'b0;
    run_op(0, 1'b0, -1, -1);
    run_op(0, 1'b0, 2, -1);
    run_op(0, 1'b1, -1, -1);
    run_op(0, 1'b0, -1, 3 + 5 * int'($urandom_range(3)));
    run_op(0, 1'b0, -1, -1);
    for (int i = 0; i < 6; i++) begin
      run_op(int'($urandom_range(40)), 1'b1, int'($urandom_range(19)), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
